// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: drains the sample FIFO and sends each 16-bit word as two 8N1 UART frames, high byte first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              send_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] dato_i,
  output logic              rd_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       words_sent_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;
  logic [2:0]        r_state;
  logic [2:0]        r_sync;
  logic [CW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic              r_byte_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_words;
  logic              w_edge;
  logic              w_shift;
  logic              w_tick;
  logic [7:0]        w_byte;
  // r_sync[1:0] is the synchroniser, r_sync[2] the previous sample for edge detect
  assign w_edge  = r_sync[1] & ~r_sync[2];
  assign w_shift = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_tick  = w_shift && (r_baud == BAUD_MAX);
  assign w_byte  = r_byte_sel ? r_data[7:0] : r_data[15:8];
  assign tx_o    = (r_state == START) ? 1'b0 : (r_state == DATA) ? w_byte[r_bit] : 1'b1;
  assign rd_o    = (r_state == REQ);
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign words_sent_o = r_words;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_sync     <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_sel <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_words    <= '0;
    end else begin
      r_sync <= {r_sync[1:0], send_i};
      r_baud <= (w_tick || !w_shift) ? '0 : r_baud + 1'b1;
      r_done <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        IDLE: if (w_edge && !r_busy) begin
          r_busy  <= 1'b1;
          r_state <= empty_i ? FINISH : REQ;
        end
        REQ: r_state <= LOAD;
        LOAD: begin
          r_data     <= dato_i;
          r_byte_sel <= 1'b0;
          r_state    <= START;
        end
        START: if (w_tick) begin
          r_bit   <= '0;
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_state <= STOP;
        end
        STOP: if (w_tick) begin
          if (!r_byte_sel) begin
            r_byte_sel <= 1'b1;
            r_state    <= START;
          end else begin
            r_words <= r_words + 1'b1;
            r_state <= empty_i ? FINISH : REQ;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: FIFO model feeds the DUT; a UART decoder pops expected bytes and frame gaps from a scoreboard.
module tb_uart_tx_fifo;
  localparam int C = 8;
  typedef struct {
    logic [7:0] b;
    int         iv;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        send_i;
  logic        empty_i;
  logic [15:0] dato_i = '0;
  logic        rd_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] words_sent_o;
  logic [15:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_done = 0;
  int n_frames = 0;
  int cyc = 0;
  int dcnt = 0;
  int k = 0;
  int last_start = -1;
  int cur_iv = 0;
  bit dact = 0;
  logic [7:0] dsh = '0;
  exp_t e;
  exp_t exp_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .send_i(send_i), .empty_i(empty_i), .dato_i(dato_i),
    .rd_o(rd_o), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .words_sent_o(words_sent_o)
  );

  always #5 clk = ~clk;
  assign empty_i = (wp == rp);

  always @(posedge clk) if (rd_o && wp != rp) begin
    dato_i <= mem[rp];
    rp <= rp + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input int iv);
    exp_t t;
    t.b = b;
    t.iv = iv;
    exp_q.push_back(t);
  endtask

  task automatic load(input logic [15:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic press();
    @(negedge clk);
    send_i = 1'b1;
    repeat (5) @(negedge clk);
    send_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done_o, 1'b1);
  endtask

  // Decoder samples mid-bit; dcnt=0 is the first cycle of the start bit
  always @(negedge clk) begin
    cyc++;
    if (done_o) n_done++;
    if (rd_o) begin
      n_rd++;
      chk("rd_on_empty", empty_i, 1'b0);
    end
    if (!rst_i) begin
      dact = 0;
      last_start = -1;
    end else if (!dact) begin
      if (tx_o == 1'b0) begin
        dact = 1;
        dcnt = 0;
        cur_iv = (last_start < 0) ? 0 : cyc - last_start;
        last_start = cyc;
        n_frames++;
      end
    end else begin
      dcnt++;
      if (dcnt % C == C / 2) begin
        k = dcnt / C;
        if (k == 0) chk("start_bit", tx_o, 1'b0);
        else if (k <= 8) dsh[k-1] = tx_o;
        else begin
          dact = 0;
          chk("stop_bit", tx_o, 1'b1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none", dsh);
          end else begin
            e = exp_q.pop_front();
            chk("byte", dsh, e.b);
            if (e.iv != 0) chk("frame_gap", cur_iv, e.iv);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_done, bf, n;
    bit bad;
    rst_i = 1'b0;
    send_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_rd", rd_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_words", words_sent_o, 16'd0);
    rst_i = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || rd_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || words_sent_o !== 16'd0) bad = 1;
    end
    chk("idle_quiet", bad, 1'b0);
    // single word A53C -> A5, 3C
    load(16'hA53C);
    push(8'hA5, 0);
    push(8'h3C, 10 * C);
    b_rd = n_rd;
    b_done = n_done;
    press();
    wait_done("t1_done");
    chk("t1_busy_at_done", busy_o, 1'b1);
    @(negedge clk);
    chk("t1_busy_after", busy_o, 1'b0);
    chk("t1_done_width", done_o, 1'b0);
    repeat (5) @(negedge clk);
    chk("t1_rd_count", n_rd - b_rd, 1);
    chk("t1_done_count", n_done - b_done, 1);
    chk("t1_words", words_sent_o, 16'd1);
    chk("t1_bytes_left", exp_q.size(), 0);
    // three words back to back with a 2-cycle inter-word gap
    load(16'h0001);
    load(16'hFFFF);
    load(16'h8000);
    push(8'h00, 0);
    push(8'h01, 10 * C);
    push(8'hFF, 10 * C + 2);
    push(8'hFF, 10 * C);
    push(8'h80, 10 * C + 2);
    push(8'h00, 10 * C);
    b_rd = n_rd;
    b_done = n_done;
    press();
    wait_done("t2_done");
    chk("t2_empty_at_done", empty_i, 1'b1);
    repeat (5) @(negedge clk);
    chk("t2_rd_count", n_rd - b_rd, 3);
    chk("t2_done_count", n_done - b_done, 1);
    chk("t2_words", words_sent_o, 16'd4);
    chk("t2_bytes_left", exp_q.size(), 0);
    // empty FIFO: done on the 4th falling edge after the pin rises
    b_rd = n_rd;
    b_done = n_done;
    @(negedge clk);
    send_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 20);
    chk("t3_done_latency", n, 4);
    send_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_rd_count", n_rd - b_rd, 0);
    chk("t3_done_count", n_done - b_done, 1);
    chk("t3_words", words_sent_o, 16'd4);
    chk("t3_busy", busy_o, 1'b0);
    // second press while busy is ignored
    load(16'h1234);
    load(16'h5678);
    push(8'h12, 0);
    push(8'h34, 10 * C);
    push(8'h56, 10 * C + 2);
    push(8'h78, 10 * C);
    b_rd = n_rd;
    b_done = n_done;
    press();
    repeat (100) @(negedge clk);
    chk("t4_busy_mid", busy_o, 1'b1);
    press();
    wait_done("t4_done");
    repeat (300) @(negedge clk);
    chk("t4_done_count", n_done - b_done, 1);
    chk("t4_rd_count", n_rd - b_rd, 2);
    chk("t4_words", words_sent_o, 16'd6);
    chk("t4_busy", busy_o, 1'b0);
    chk("t4_bytes_left", exp_q.size(), 0);
    // reset during the data bits of the low byte
    load(16'hC3A1);
    load(16'h7E42);
    push(8'hC3, 0);
    bf = n_frames;
    press();
    n = 0;
    while (n_frames < bf + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_second_frame", n_frames, bf + 2);
    repeat (3 * C) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("t5_tx_on_reset", tx_o, 1'b1);
    chk("t5_words_on_reset", words_sent_o, 16'd0);
    chk("t5_busy_on_reset", busy_o, 1'b0);
    chk("t5_rd_on_reset", rd_o, 1'b0);
    chk("t5_bytes_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    push(8'h7E, 0);
    push(8'h42, 10 * C);
    press();
    wait_done("t5_done");
    repeat (5) @(negedge clk);
    chk("t5_words", words_sent_o, 16'd1);
    chk("t5_bytes_after", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
